// File: rtl/timer_reload_sched.sv
// Reload-table sequencer for the 8-bit timer: loads each table entry, runs until the
// selected terminal-count flag fires, acknowledges it, then moves to the next entry.
module timer_reload_sched #(
    parameter int DEPTH       = 4,
    parameter int AW          = 2,
    parameter int LOAD_CYCLES = 2
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          start,
    input  logic          stop,
    input  logic          periodic,
    input  logic          dw_cfg,
    input  logic [1:0]    clk_sel_cfg,
    input  logic [AW-1:0] num_ent,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          udf_trig,
    input  logic          ovf_trig,
    output logic [7:0]    tcr_o,
    output logic [7:0]    tdr_o,
    output logic [1:0]    trig_clr,
    output logic          busy,
    output logic          irq,
    output logic          done,
    output logic [AW-1:0] cur_idx,
    output logic [7:0]    evt_cnt
);

    localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    // Timer control byte: [7] load, [5] dw, [4] en, [1:0] clk_sel, other bits zero.
    function automatic logic [7:0] tcr_pack(input logic load, input logic dw,
                                            input logic en, input logic [1:0] clk_sel);
        return {load, 1'b0, dw, en, 2'b00, clk_sel};
    endfunction

    state_t         state_r, state_s;
    logic [7:0]     tbl_r [DEPTH];
    logic           per_r, per_s;
    logic           dw_r, dw_s;
    logic [1:0]     clk_sel_r, clk_sel_s;
    logic [AW-1:0]  num_ent_r, num_ent_s;
    logic [LCW-1:0] load_cnt_r, load_cnt_s;

    logic [7:0]     tcr_r, tcr_s;
    logic [7:0]     tdr_r, tdr_s;
    logic [1:0]     trig_clr_r, trig_clr_s;
    logic           busy_r, busy_s;
    logic           irq_r, irq_s;
    logic           done_r, done_s;
    logic [AW-1:0]  idx_r, idx_s;
    logic [7:0]     evt_cnt_r, evt_cnt_s;
    logic           evt_s;

    assign evt_s = dw_r ? udf_trig : ovf_trig;

    // Reload table storage; writes are accepted in every state.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_r[i] <= 8'h00;
            end
        end else if (wr_en) begin
            tbl_r[wr_addr] <= wr_data;
        end else begin
            tbl_r <= tbl_r;
        end
    end

    // Next-state and next-output logic; outputs are registered so they track the state.
    always_comb begin
        state_s    = state_r;
        per_s      = per_r;
        dw_s       = dw_r;
        clk_sel_s  = clk_sel_r;
        num_ent_s  = num_ent_r;
        load_cnt_s = load_cnt_r;
        tcr_s      = tcr_r;
        tdr_s      = tdr_r;
        trig_clr_s = 2'b00;
        irq_s      = 1'b0;
        done_s     = 1'b0;
        idx_s      = idx_r;
        evt_cnt_s  = evt_cnt_r;

        case (state_r)
            ST_IDLE: begin
                tcr_s = 8'h00;
                if (start && !stop) begin
                    per_s      = periodic;
                    dw_s       = dw_cfg;
                    clk_sel_s  = clk_sel_cfg;
                    num_ent_s  = num_ent;
                    idx_s      = {AW{1'b0}};
                    evt_cnt_s  = 8'h00;
                    load_cnt_s = {LCW{1'b0}};
                    tdr_s      = tbl_r[0];
                    tcr_s      = tcr_pack(1'b1, dw_cfg, 1'b0, clk_sel_cfg);
                    state_s    = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                tdr_s = tbl_r[idx_r];
                if (load_cnt_r == LOAD_LAST) begin
                    tcr_s   = tcr_pack(1'b0, dw_r, 1'b1, clk_sel_r);
                    state_s = ST_RUN;
                end else begin
                    load_cnt_s = load_cnt_r + LCW'(1);
                    state_s    = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (evt_s) begin
                    trig_clr_s = dw_r ? 2'b10 : 2'b01;
                    irq_s      = 1'b1;
                    evt_cnt_s  = evt_cnt_r + 8'd1;
                    tcr_s      = tcr_pack(1'b0, dw_r, 1'b0, clk_sel_r);
                    state_s    = ST_ACK;
                    // Successor of ACK is decided here; done_r then steers ACK to IDLE.
                    if (idx_r != num_ent_r) begin
                        idx_s = idx_r + AW'(1);
                    end else if (per_r) begin
                        idx_s = {AW{1'b0}};
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_ACK: begin
                if (done_r) begin
                    tcr_s   = 8'h00;
                    state_s = ST_IDLE;
                end else begin
                    load_cnt_s = {LCW{1'b0}};
                    tdr_s      = tbl_r[idx_r];
                    tcr_s      = tcr_pack(1'b1, dw_r, 1'b0, clk_sel_r);
                    state_s    = ST_LOAD;
                end
            end
            default: begin
                tcr_s   = 8'h00;
                state_s = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a same-cycle event.
        if (stop && (state_r != ST_IDLE)) begin
            state_s    = ST_IDLE;
            tcr_s      = 8'h00;
            tdr_s      = tdr_r;
            trig_clr_s = 2'b11;
            irq_s      = 1'b0;
            done_s     = 1'b0;
            idx_s      = idx_r;
            evt_cnt_s  = evt_cnt_r;
            load_cnt_s = load_cnt_r;
        end else begin
            state_s = state_s;
        end

        busy_s = (state_s != ST_IDLE);
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r    <= ST_IDLE;
            per_r      <= 1'b0;
            dw_r       <= 1'b0;
            clk_sel_r  <= 2'b00;
            num_ent_r  <= {AW{1'b0}};
            load_cnt_r <= {LCW{1'b0}};
            tcr_r      <= 8'h00;
            tdr_r      <= 8'h00;
            trig_clr_r <= 2'b00;
            busy_r     <= 1'b0;
            irq_r      <= 1'b0;
            done_r     <= 1'b0;
            idx_r      <= {AW{1'b0}};
            evt_cnt_r  <= 8'h00;
        end else begin
            state_r    <= state_s;
            per_r      <= per_s;
            dw_r       <= dw_s;
            clk_sel_r  <= clk_sel_s;
            num_ent_r  <= num_ent_s;
            load_cnt_r <= load_cnt_s;
            tcr_r      <= tcr_s;
            tdr_r      <= tdr_s;
            trig_clr_r <= trig_clr_s;
            busy_r     <= busy_s;
            irq_r      <= irq_s;
            done_r     <= done_s;
            idx_r      <= idx_s;
            evt_cnt_r  <= evt_cnt_s;
        end
    end

    assign tcr_o    = tcr_r;
    assign tdr_o    = tdr_r;
    assign trig_clr = trig_clr_r;
    assign busy     = busy_r;
    assign irq      = irq_r;
    assign done     = done_r;
    assign cur_idx  = idx_r;
    assign evt_cnt  = evt_cnt_r;

endmodule

// File: tb/tb_timer_reload_sched.sv
// Scoreboard bench for timer_reload_sched: expected LOAD entries and flag-clear
// responses are queued by the stimulus and checked by an independent monitor.
module tb_timer_reload_sched;

    localparam int LOAD_CYCLES = 2;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       start = 1'b0, stop = 1'b0, periodic = 1'b0, dw_cfg = 1'b0;
    logic [1:0] clk_sel_cfg = 2'b00;
    logic [1:0] num_ent = 2'b00;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'b00;
    logic [7:0] wr_data = 8'h00;
    logic       udf_trig = 1'b0, ovf_trig = 1'b0;
    logic [7:0] tcr_o, tdr_o, evt_cnt;
    logic [1:0] trig_clr, cur_idx;
    logic       busy, irq, done;

    timer_reload_sched #(.DEPTH(4), .AW(2), .LOAD_CYCLES(LOAD_CYCLES)) dut (
        .pclk(pclk), .presetn(presetn), .start(start), .stop(stop),
        .periodic(periodic), .dw_cfg(dw_cfg), .clk_sel_cfg(clk_sel_cfg),
        .num_ent(num_ent), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .udf_trig(udf_trig), .ovf_trig(ovf_trig), .tcr_o(tcr_o), .tdr_o(tdr_o),
        .trig_clr(trig_clr), .busy(busy), .irq(irq), .done(done),
        .cur_idx(cur_idx), .evt_cnt(evt_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit         is_ack;
        logic [7:0] tdr;
        logic [7:0] tcr;
        logic [1:0] trig;
        logic       irq;
        logic       done;
        logic [1:0] idx;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_load(input logic [7:0] tdr, input logic [7:0] tcr, input logic [1:0] idx);
        exp_t e;
        e = '{is_ack: 1'b0, tdr: tdr, tcr: tcr, trig: 2'b00, irq: 1'b0, done: 1'b0, idx: idx, cnt: 8'h00};
        q.push_back(e);
    endtask

    task automatic push_ack(input logic [1:0] trig, input logic irq_e, input logic done_e,
                            input logic [1:0] idx, input logic [7:0] cnt, input logic [7:0] tcr);
        exp_t e;
        e = '{is_ack: 1'b1, tdr: 8'h00, tcr: tcr, trig: trig, irq: irq_e, done: done_e, idx: idx, cnt: cnt};
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic wr_tbl(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_udf();
        udf_trig = 1'b1; tick(); udf_trig = 1'b0;
    endtask

    task automatic pulse_ovf();
        ovf_trig = 1'b1; tick(); ovf_trig = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_run();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tcr_o[4]) begin seen = 1'b1; break; end
            tick();
        end
        chk("wait_run", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin seen = 1'b1; break; end
            tick();
        end
        chk("wait_idle", {31'd0, seen}, 32'd1);
    endtask

    // Monitor: pops an expectation at each LOAD entry and each flag-clear response.
    bit prev_load = 1'b0;
    int load_len = 0;
    always @(negedge pclk) begin
        exp_t e;
        if (!presetn) begin
            prev_load = 1'b0;
            load_len = 0;
        end else begin
            if (tcr_o[7]) begin
                if (!prev_load) begin
                    load_len = 1;
                    if (q.size() == 0) chk("unexpected_load", 32'd1, 32'd0);
                    else begin
                        e = q.pop_front();
                        chk("load_kind", {31'd0, e.is_ack}, 32'd0);
                        chk("load_tdr", {24'd0, tdr_o}, {24'd0, e.tdr});
                        chk("load_tcr", {24'd0, tcr_o}, {24'd0, e.tcr});
                        chk("load_idx", {30'd0, cur_idx}, {30'd0, e.idx});
                    end
                end else begin
                    load_len++;
                end
            end else if (prev_load) begin
                chk("load_len", load_len, LOAD_CYCLES);
            end else begin
                load_len = 0;
            end
            if (trig_clr != 2'b00) begin
                if (q.size() == 0) chk("unexpected_clr", {30'd0, trig_clr}, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("ack_kind", {31'd0, e.is_ack}, 32'd1);
                    chk("ack_trig_clr", {30'd0, trig_clr}, {30'd0, e.trig});
                    chk("ack_irq", {31'd0, irq}, {31'd0, e.irq});
                    chk("ack_done", {31'd0, done}, {31'd0, e.done});
                    chk("ack_idx", {30'd0, cur_idx}, {30'd0, e.idx});
                    chk("ack_evt_cnt", {24'd0, evt_cnt}, {24'd0, e.cnt});
                    chk("ack_tcr", {24'd0, tcr_o}, {24'd0, e.tcr});
                end
            end
            prev_load = tcr_o[7];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tcr", {24'd0, tcr_o}, 32'd0);
        presetn = 1'b1;
        tick();

        // Reset mid-RUN, then confirm the table was cleared.
        wr_tbl(2'd0, 8'h55);
        num_ent = 2'd0; dw_cfg = 1'b1; periodic = 1'b0; clk_sel_cfg = 2'b00;
        push_load(8'h55, 8'hA0, 2'd0);
        pulse_start();
        wait_run();
        presetn = 1'b0;
        #1;
        chk("arst_tcr", {24'd0, tcr_o}, 32'd0);
        chk("arst_tdr", {24'd0, tdr_o}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_trig_clr", {30'd0, trig_clr}, 32'd0);
        chk("arst_evt_cnt", {24'd0, evt_cnt}, 32'd0);
        tick();
        presetn = 1'b1;
        tick();
        push_load(8'h00, 8'hA0, 2'd0);
        pulse_start();
        wait_run();
        chk("tbl_cleared_tdr", {24'd0, tdr_o}, 32'd0);
        push_ack(2'b10, 1'b1, 1'b1, 2'd0, 8'd1, 8'h20);
        pulse_udf();
        wait_idle();

        // One-shot, two entries, counting down.
        wr_tbl(2'd0, 8'h03);
        wr_tbl(2'd1, 8'h05);
        num_ent = 2'd1; dw_cfg = 1'b1; periodic = 1'b0; clk_sel_cfg = 2'b00;
        push_load(8'h03, 8'hA0, 2'd0);
        pulse_start();
        wait_run();
        chk("run_tcr", {24'd0, tcr_o}, 32'h30);
        pulse_ovf();
        chk("ovf_ignored_tcr", {24'd0, tcr_o}, 32'h30);
        push_ack(2'b10, 1'b1, 1'b0, 2'd1, 8'd1, 8'h20);
        push_load(8'h05, 8'hA0, 2'd1);
        pulse_udf();
        wait_run();
        push_ack(2'b10, 1'b1, 1'b1, 2'd1, 8'd2, 8'h20);
        pulse_udf();
        wait_idle();
        chk("oneshot_idle_tcr", {24'd0, tcr_o}, 32'h00);

        // Periodic single entry, counting up, 256 events wrap the counter.
        wr_tbl(2'd0, 8'h11);
        num_ent = 2'd0; dw_cfg = 1'b0; periodic = 1'b1; clk_sel_cfg = 2'b01;
        push_load(8'h11, 8'h81, 2'd0);
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] c;
            c = 8'(i + 1);
            wait_run();
            if ((i % 64) == 3) pulse_udf();
            push_ack(2'b01, 1'b1, 1'b0, 2'd0, c, 8'h01);
            push_load(8'h11, 8'h81, 2'd0);
            pulse_ovf();
        end

        // Stop in the same cycle as an event.
        wait_run();
        push_ack(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 8'h00);
        stop = 1'b1; ovf_trig = 1'b1;
        tick();
        stop = 1'b0; ovf_trig = 1'b0;
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_irq", {31'd0, irq}, 32'd0);
        tick();
        chk("stop_clr_one_cycle", {30'd0, trig_clr}, 32'd0);

        // start together with stop in IDLE does nothing.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", {31'd0, busy}, 32'd0);
        chk("start_stop_tcr", {24'd0, tcr_o}, 32'd0);

        // Table write during RUN and start while busy.
        wr_tbl(2'd0, 8'h22);
        wr_tbl(2'd1, 8'h44);
        num_ent = 2'd1; dw_cfg = 1'b1; periodic = 1'b0; clk_sel_cfg = 2'b00;
        push_load(8'h22, 8'hA0, 2'd0);
        pulse_start();
        wait_run();
        wr_tbl(2'd1, 8'h7F);
        pulse_start();
        chk("busy_start_tcr", {24'd0, tcr_o}, 32'h30);
        chk("busy_start_idx", {30'd0, cur_idx}, 32'd0);
        push_ack(2'b10, 1'b1, 1'b0, 2'd1, 8'd1, 8'h20);
        push_load(8'h7F, 8'hA0, 2'd1);
        pulse_udf();
        wait_run();
        push_ack(2'b10, 1'b1, 1'b1, 2'd1, 8'd2, 8'h20);
        pulse_udf();
        wait_idle();

        repeat (4) tick();
        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
